// File: rtl/ins_fetch_queue.sv
// Instruction prefetch queue: keeps at most one fetch in flight to the memory adapter
// and buffers returned words with their addresses until the consumer pops them.
module ins_fetch_queue #(
   parameter int          QUEUE_DEPTH = 4,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        try_start_prefetch_task,
   output logic [31:0] prefetch_addr,
   input  logic        prefetch_task_accepted,
   input  logic        prefetch_task_done,
   input  logic [31:0] prefetch_ins_full,
   output logic        ins_valid,
   output logic [31:0] ins_out,
   output logic [31:0] ins_pc,
   input  logic        ins_ready,
   input  logic        flush_in,
   input  logic [31:0] flush_pc
);

   localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_DISCARD = 2'd3;

   logic [1:0]    state;
   logic [31:0]   fetch_pc;
   logic [31:0]   addr_q;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [31:0]   ins_mem [QUEUE_DEPTH];
   logic [31:0]   pc_mem  [QUEUE_DEPTH];

   logic push;
   logic pop;
   logic full;

   assign full = (count == DEPTH_C);
   assign push = (state == S_WAIT) && prefetch_task_done && !flush_in;
   assign pop  = (count != '0) && ins_ready && !flush_in;

   assign try_start_prefetch_task = (state == S_REQ);
   assign prefetch_addr           = addr_q;
   assign ins_valid               = (count != '0);
   assign ins_out                 = ins_mem[head];
   assign ins_pc                  = pc_mem[head];

   // A flush never stops an accepted task; DISCARD swallows its done word instead.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         addr_q   <= '0;
      end else if (rdy_in) begin
         if (flush_in)
            fetch_pc <= flush_pc;
         case (state)
            S_IDLE: begin
               if (!flush_in && !full) begin
                  state  <= S_REQ;
                  addr_q <= fetch_pc;
               end
            end
            S_REQ: begin
               if (prefetch_task_accepted)
                  state <= flush_in ? S_DISCARD : S_WAIT;
               else if (flush_in)
                  state <= S_IDLE;
            end
            S_WAIT: begin
               if (prefetch_task_done) begin
                  state <= S_IDLE;
                  if (!flush_in)
                     fetch_pc <= fetch_pc + 32'd4;
               end else if (flush_in) begin
                  state <= S_DISCARD;
               end
            end
            default: begin
               if (prefetch_task_done)
                  state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            ins_mem[i] <= '0;
            pc_mem[i]  <= '0;
         end
      end else if (rdy_in) begin
         if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) begin
               ins_mem[tail] <= prefetch_ins_full;
               pc_mem[tail]  <= fetch_pc;
               tail          <= tail + 1'b1;
            end
            if (pop)
               head <= head + 1'b1;
            if (push && !pop)
               count <= count + 1'b1;
            else if (pop && !push)
               count <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Bench for ins_fetch_queue: acts as memory adapter and consumer, checking the DUT
// against a queue-of-words reference model plus directed timing scenarios.
module tb_ins_fetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        try_start_prefetch_task;
   logic [31:0] prefetch_addr;
   logic        prefetch_task_accepted;
   logic        prefetch_task_done;
   logic [31:0] prefetch_ins_full;
   logic        ins_valid;
   logic [31:0] ins_out;
   logic [31:0] ins_pc;
   logic        ins_ready;
   logic        flush_in;
   logic [31:0] flush_pc;

   ins_fetch_queue #(.QUEUE_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk_in                  (clk_in),
      .rst_in                  (rst_in),
      .rdy_in                  (rdy_in),
      .try_start_prefetch_task (try_start_prefetch_task),
      .prefetch_addr           (prefetch_addr),
      .prefetch_task_accepted  (prefetch_task_accepted),
      .prefetch_task_done      (prefetch_task_done),
      .prefetch_ins_full       (prefetch_ins_full),
      .ins_valid               (ins_valid),
      .ins_out                 (ins_out),
      .ins_pc                  (ins_pc),
      .ins_ready               (ins_ready),
      .flush_in                (flush_in),
      .flush_pc                (flush_pc)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   // Reference model: expected queue contents {word, pc}, next fetch address, in-flight task.
   logic [63:0] mq[$];
   logic [31:0] exp_pc;
   bit          inflight;
   bit          discard;
   int          lat;
   int          pushes;

   // Stimulus knobs (percentages and latency range).
   int          p_rdy = 100, p_flush = 0, p_ready = 0, p_acc = 100;
   int          lat_min = 0, lat_max = 0;
   bit          force_flush = 0;
   logic [31:0] force_fpc = '0;
   bit          force_word_en = 0;
   logic [31:0] force_word = '0;
   bit          stray_done = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      exp_pc   = RPC;
      inflight = 0;
      discard  = 0;
      lat      = 0;
   endtask

   // Called at a falling edge: check outputs, drive inputs, update model, advance one cycle.
   task automatic step();
      bit rdy, fl, rd, acc, dn, pop;
      logic [31:0] fpc, word;
      chk("ins_valid", 32'(ins_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("ins_out", ins_out, mq[0][63:32]);
         chk("ins_pc", ins_pc, mq[0][31:0]);
      end
      if (try_start_prefetch_task === 1'b1) begin
         chk("req_room", 32'(mq.size() < DEPTH), 32'd1);
         chk("prefetch_addr", prefetch_addr, exp_pc);
      end
      if (inflight)
         chk("one_in_flight", 32'(try_start_prefetch_task), 32'd0);

      rdy  = ($urandom_range(99) < p_rdy);
      fl   = force_flush || ($urandom_range(99) < p_flush);
      fpc  = force_flush ? force_fpc : ($urandom & 32'h0000_fffc);
      rd   = ($urandom_range(99) < p_ready);
      acc  = (try_start_prefetch_task === 1'b1) && ($urandom_range(99) < p_acc);
      dn   = rdy && inflight && (lat == 0);
      word = force_word_en ? force_word : $urandom;

      rdy_in                 = rdy;
      flush_in               = fl;
      flush_pc               = fpc;
      ins_ready              = rd;
      prefetch_task_accepted = acc;
      prefetch_task_done     = dn || stray_done;
      prefetch_ins_full      = word;

      if (rdy) begin
         pop = (mq.size() != 0) && rd;
         if (fl) begin
            mq.delete();
            exp_pc = fpc;
         end else begin
            if (pop) void'(mq.pop_front());
            if (dn && !discard) begin
               mq.push_back({word, exp_pc});
               exp_pc += 32'd4;
               pushes++;
            end
         end
         if (dn) begin
            inflight = 0;
            discard  = 0;
         end else if (inflight) begin
            if (fl) discard = 1;
            if (lat > 0) lat--;
         end
         if (acc) begin
            inflight = 1;
            discard  = fl;
            lat      = $urandom_range(lat_max, lat_min);
         end
      end
      @(negedge clk_in);
   endtask

   task automatic wait_req(input string tag, output logic [31:0] addr);
      bit found = 0;
      addr = 'x;
      for (int i = 0; i < 30 && !found; i++) begin
         if (try_start_prefetch_task === 1'b1) begin
            found = 1;
            addr  = prefetch_addr;
         end else begin
            step();
         end
      end
      chk({tag, "_req_seen"}, 32'(found), 32'd1);
   endtask

   initial begin
      logic [31:0] a;
      bit          any_req;
      rst_in = 1'b1;
      rdy_in = 1'b0; flush_in = 1'b0; flush_pc = '0; ins_ready = 1'b0;
      prefetch_task_accepted = 1'b0; prefetch_task_done = 1'b0; prefetch_ins_full = '0;
      model_reset();
      pushes = 0;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;

      // First fetch: accept after 1 cycle, done 3 cycles later with 0x13.
      lat_min = 2; lat_max = 2; force_word_en = 1; force_word = 32'h0000_0013;
      chk("rst_try", 32'(try_start_prefetch_task), 32'd0);
      chk("rst_addr", prefetch_addr, 32'h0);
      chk("rst_valid", 32'(ins_valid), 32'd0);
      chk("rst_ins_out", ins_out, 32'h0);
      chk("rst_ins_pc", ins_pc, 32'h0);
      step();
      chk("first_try", 32'(try_start_prefetch_task), 32'd1);
      chk("first_addr", prefetch_addr, RPC);
      repeat (4) step();
      chk("first_valid", 32'(ins_valid), 32'd1);
      chk("first_ins_out", ins_out, 32'h0000_0013);
      chk("first_ins_pc", ins_pc, 32'h0);
      chk("idle_gap_try", 32'(try_start_prefetch_task), 32'd0);
      step();
      chk("second_try", 32'(try_start_prefetch_task), 32'd1);
      chk("second_addr", prefetch_addr, 32'h4);
      force_word_en = 0;

      // Fill to capacity with no consumer, then one pop reopens fetching.
      lat_min = 0; lat_max = 0;
      repeat (30) step();
      any_req = 0;
      for (int i = 0; i < 10; i++) begin
         if (try_start_prefetch_task === 1'b1) any_req = 1;
         step();
      end
      chk("full_no_req", 32'(any_req), 32'd0);
      chk("full_head_pc", ins_pc, 32'h0);
      p_ready = 100;
      step();
      p_ready = 0;
      wait_req("reopen", a);
      chk("reopen_addr", a, 32'd16);

      // Flush during WAIT: in-flight word is discarded.
      p_ready = 50; lat_min = 3; lat_max = 3;
      for (int i = 0; i < 30 && !inflight; i++) step();
      chk("wait_reached", 32'(inflight), 32'd1);
      force_flush = 1; force_fpc = 32'h0000_1000;
      force_word_en = 1; force_word = 32'hDEAD_BEEF;
      p_ready = 0;
      step();
      force_flush = 0;
      wait_req("flush", a);
      chk("flush_addr", a, 32'h0000_1000);
      chk("flush_empty", 32'(ins_valid), 32'd0);
      force_word_en = 0;

      // Simultaneous push/pop with two entries, walking pointers past the wrap point.
      lat_min = 0; lat_max = 0;
      for (int i = 0; i < 30 && mq.size() != 2; i++) step();
      chk("two_entries", 32'(ins_valid), 32'd1);
      p_ready = 100;
      repeat (16) step();

      // rdy_in low during REQ with accept held.
      p_ready = 0;
      wait_req("freeze", a);
      p_rdy = 0;
      for (int i = 0; i < 5; i++) begin
         chk("freeze_try", 32'(try_start_prefetch_task), 32'd1);
         chk("freeze_addr", prefetch_addr, a);
         step();
      end
      p_rdy = 100; lat_min = 3; lat_max = 3;
      chk("thaw_try", 32'(try_start_prefetch_task), 32'd1);
      step();
      chk("thaw_wait", 32'(try_start_prefetch_task), 32'd0);

      // Reset mid-WAIT, then a stray done pulse.
      step();
      chk("mid_wait", 32'(inflight), 32'd1);
      rst_in = 1'b1;
      prefetch_task_accepted = 1'b0; prefetch_task_done = 1'b0; flush_in = 1'b0;
      model_reset();
      @(negedge clk_in);
      chk("rst2_try", 32'(try_start_prefetch_task), 32'd0);
      chk("rst2_valid", 32'(ins_valid), 32'd0);
      chk("rst2_addr", prefetch_addr, 32'h0);
      rst_in = 1'b0;
      stray_done = 1;
      step();
      stray_done = 0;
      chk("stray_valid", 32'(ins_valid), 32'd0);
      wait_req("after_rst", a);
      chk("after_rst_addr", a, RPC);

      // Randomized traffic.
      p_rdy = 85; p_flush = 4; p_ready = 50; p_acc = 60; lat_min = 0; lat_max = 4;
      pushes = 0;
      repeat (3000) step();
      chk("liveness", 32'(pushes > 100), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ins_fetch_queue.md
INS_FETCH_QUEUE -- requirements
Module: ins_fetch_queue

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, queue entry count; power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk_in, input, 1, system clock; all state updates on rising edge.
REQ-004 SHALL have port rst_in, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port rdy_in, input, 1, ready; low freezes all state.
REQ-006 SHALL have port try_start_prefetch_task, output, 1, fetch request to memory adapter.
REQ-007 SHALL have port prefetch_addr, output, 32, fetch word address.
REQ-008 SHALL have port prefetch_task_accepted, input, 1, adapter took the request.
REQ-009 SHALL have port prefetch_task_done, input, 1, one-cycle pulse; fetched word valid.
REQ-010 SHALL have port prefetch_ins_full, input, 32, fetched instruction word.
REQ-011 SHALL have port ins_valid, output, 1, queue head valid.
REQ-012 SHALL have port ins_out, output, 32, head instruction.
REQ-013 SHALL have port ins_pc, output, 32, head instruction address.
REQ-014 SHALL have port ins_ready, input, 1, consumer pops head when ins_valid && ins_ready.
REQ-015 SHALL have port flush_in, input, 1, redirect request.
REQ-016 SHALL have port flush_pc, input, 32, redirect target.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, DISCARD; at most one fetch in flight.
REQ-018 SHALL assert try_start_prefetch_task iff state==REQ; prefetch_addr SHALL equal fetch_pc and be stable throughout REQ.
REQ-019 IDLE->REQ SHALL occur when count<QUEUE_DEPTH and flush_in low.
REQ-020 REQ->WAIT SHALL occur on prefetch_task_accepted; REQ otherwise holds.
REQ-021 WAIT->IDLE SHALL occur on prefetch_task_done; {prefetch_ins_full, fetch_pc} SHALL be pushed at the tail the same edge, and fetch_pc SHALL become fetch_pc+4, 32-bit wrap-around.
REQ-022 Minimum fetch-to-fetch spacing SHALL be: IDLE 1 cycle, REQ at least 1, WAIT until done; an IDLE->REQ re-request SHALL occur the cycle after done if space remains.
REQ-023 ins_valid, ins_out and ins_pc SHALL be driven combinationally from the head entry; ins_valid = (count!=0).
REQ-024 Simultaneous push and pop SHALL leave count unchanged; head/tail pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-025 Request issue SHALL require count<QUEUE_DEPTH; with one in flight, push SHALL never overflow; pop on empty SHALL be ignored.
REQ-026 flush_in SHALL have priority over push and pop: queue count->0, fetch_pc<=flush_pc.
REQ-027 Flush in IDLE or REQ without accept SHALL go to IDLE; try_start SHALL drop next cycle.
REQ-028 Flush in WAIT, or in REQ coinciding with accept, SHALL go to DISCARD; DISCARD SHALL drop the next done word (no push, fetch_pc unchanged) and return to IDLE.
REQ-029 Flush in WAIT coinciding with done SHALL drop that word and go to IDLE.
REQ-030 Further flush in DISCARD SHALL update fetch_pc only and stay in DISCARD.
REQ-031 With rdy_in low, no state, pointer, count or fetch_pc SHALL change; outputs hold their values.

Reset
REQ-032 On rst_in high, asynchronously: state=IDLE, count=0, head=tail=0, fetch_pc=RESET_PC, try_start_prefetch_task=0, ins_valid=0; prefetch_addr, ins_out and ins_pc SHALL be 0 until the first request or push.
REQ-033 Reset mid-fetch SHALL abandon the in-flight task; done pulses arriving in IDLE SHALL be ignored.

Verification
REQ-034 Reset, adapter accepts after 1 cycle, done after 3 cycles with 32'h00000013 -> prefetch_addr 0, then ins_valid=1, ins_out=32'h13, ins_pc=0; next request at 4.
REQ-035 ins_ready held low, 5 fetches offered -> exactly 4 pushed (PCs 0,4,8,12); try_start stays 0 while count==4; one pop reopens fetching at PC 16.
REQ-036 Flush to 32'h1000 while in WAIT, done returns 32'hDEADBEEF -> word discarded, queue empty, next prefetch_addr=32'h1000.
REQ-037 Push and pop in the same cycle with count=2 -> count stays 2, pointer wrap at slot 3->0 correct, order preserved.
REQ-038 rdy_in low for 5 cycles during REQ with accept asserted -> no transition; rdy_in high -> proceeds to WAIT.
REQ-039 rst_in asserted mid-WAIT, stray done pulse after release -> ignored; first fetch at RESET_PC.
